// File: rtl/pn_pkg.sv
// Shared types and default sizing for the Petri-net firing controller.
package pn_pkg;

    // Default sizing for the current net: 15 transitions, 4-bit index, 30-bit count.
    localparam int PN_NT = 15;
    localparam int PN_IW = 4;
    localparam int PN_CW = 30;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVAL,
        ST_FIRE,
        ST_PAUSE,
        ST_DEAD,
        ST_DONE
    } state_t;

    // States in which the controller is at rest and will accept a new start.
    function automatic logic is_quiescent(state_t s);
        return (s == ST_IDLE) || (s == ST_DEAD) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/pn_rr_pick.sv
// Round-robin picker: rotate the candidate vector so the search starts just
// above ptr, take the lowest set bit, then rotate the index back.
module pn_rr_pick
    import pn_pkg::*;
#(
    parameter int NT = PN_NT,
    parameter int IW = PN_IW
) (
    input  logic [NT-1:0] cand,
    input  logic [IW-1:0] ptr,
    output logic [NT-1:0] gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [IW-1:0] start_pos;
    logic [NT-1:0] rotated;
    logic [IW-1:0] offset;
    logic [IW:0]   sum;

    // Rotate so that bit 0 of 'rotated' is candidate (ptr+1) mod NT.
    always_comb begin
        // NOTE: every signal written in always_comb gets a value on every path; the defaults come first so no latch can be inferred.
        start_pos = '0;
        if (ptr < IW'(NT - 1)) begin
            start_pos = ptr + IW'(1);
        end
        rotated = NT'({cand, cand} >> start_pos);
    end

    // Find the first set bit of the rotated vector and map it back to a net index.
    always_comb begin
        offset = '0;
        any    = 1'b0;
        for (int i = NT - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = IW'(i);
                any    = 1'b1;
            end
        end
        sum = {1'b0, start_pos} + {1'b0, offset};
        if (sum >= (IW + 1)'(NT)) begin
            sum = sum - (IW + 1)'(NT);
        end
        gnt_idx    = sum[IW-1:0];
        gnt_onehot = any ? (NT'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/pn_fire_scheduler.sv
// Firing sequencer for the Petri-net marking datapath: picks one enabled
// transition per round (immediate class first, round-robin within a class),
// handshakes it with the datapath, and tracks count, deadlock and limit.
module pn_fire_scheduler
    import pn_pkg::*;
#(
    parameter int NT        = PN_NT,
    parameter int IW        = PN_IW,
    parameter int CW        = PN_CW,
    parameter int MAX_FIRES = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          halt,
    input  logic          step_mode,
    input  logic          step_req,
    input  logic [NT-1:0] enabled,
    input  logic [NT-1:0] prio_mask,
    output logic          fire_valid,
    output logic [NT-1:0] fire_onehot,
    output logic [IW-1:0] fire_idx,
    input  logic          fire_ack,
    output logic          busy,
    output logic          deadlock,
    output logic          limit_hit,
    output logic [CW-1:0] fire_count
);

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] rr_ptr_q;
    logic [NT-1:0] onehot_q;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] count_q;
    logic          deadlock_q;
    logic          limit_hit_q;

    logic [NT-1:0] imm_cand;
    logic [NT-1:0] cand;
    logic [NT-1:0] pick_onehot;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [CW-1:0] count_inc;
    logic          limit_reach;

    // Immediate transitions, when any are enabled, shut out the timed class.
    assign imm_cand = enabled & prio_mask;
    assign cand     = (imm_cand != '0) ? imm_cand : enabled;

    pn_rr_pick #(
        .NT (NT),
        .IW (IW)
    ) u_pick (
        .cand       (cand),
        .ptr        (rr_ptr_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    // Saturating increment, and the limit test applied to the post-ack count.
    assign count_inc   = (&count_q) ? count_q : count_q + CW'(1);
    assign limit_reach = (MAX_FIRES != 0) && (count_inc == CW'(MAX_FIRES));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DEAD, ST_DONE: begin
                if (start) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                if (!pick_any)  state_d = ST_DEAD;
                else if (halt)  state_d = ST_IDLE;
                else            state_d = ST_FIRE;
            end
            ST_FIRE: begin
                // The request is never withdrawn; only the ack releases FIRE.
                if (fire_ack) begin
                    if (limit_reach)    state_d = ST_DONE;
                    else if (halt)      state_d = ST_IDLE;
                    else if (step_mode) state_d = ST_PAUSE;
                    else                state_d = ST_EVAL;
                end
            end
            ST_PAUSE: begin
                if (halt)                       state_d = ST_IDLE;
                else if (step_req || !step_mode) state_d = ST_EVAL;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant latch, round-robin pointer, firing count and sticky status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= IW'(NT - 1);
            onehot_q    <= '0;
            idx_q       <= '0;
            count_q     <= '0;
            deadlock_q  <= 1'b0;
            limit_hit_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DEAD, ST_DONE: begin
                    if (start) begin
                        rr_ptr_q    <= IW'(NT - 1);
                        count_q     <= '0;
                        deadlock_q  <= 1'b0;
                        limit_hit_q <= 1'b0;
                    end
                end
                ST_EVAL: begin
                    if (!pick_any) begin
                        deadlock_q <= 1'b1;
                    end else if (!halt) begin
                        onehot_q <= pick_onehot;
                        idx_q    <= pick_idx;
                    end
                end
                ST_FIRE: begin
                    if (fire_ack) begin
                        rr_ptr_q <= idx_q;
                        count_q  <= count_inc;
                        if (limit_reach) limit_hit_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Grant outputs read zero outside FIRE so the datapath never sees a stale index.
    assign fire_valid  = (state_q == ST_FIRE);
    assign fire_onehot = fire_valid ? onehot_q : '0;
    assign fire_idx    = fire_valid ? idx_q : '0;
    assign busy        = !is_quiescent(state_q);
    assign deadlock    = deadlock_q;
    assign limit_hit   = limit_hit_q;
    assign fire_count  = count_q;

endmodule

// File: tb/tb_pn_fire_scheduler.sv
// Self-checking bench for pn_fire_scheduler: a transaction-level model of the
// selection rule and firing count, plus directed scenarios with literal grants.
module tb_pn_fire_scheduler;

    localparam int NT = 15;
    localparam int IW = 4;
    localparam int CW = 30;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          halt = 1'b0;
    logic          step_mode = 1'b0;
    logic          step_req = 1'b0;
    logic [NT-1:0] enabled = '0;
    logic [NT-1:0] prio_mask = '0;
    logic          fire_valid;
    logic [NT-1:0] fire_onehot;
    logic [IW-1:0] fire_idx;
    logic          fire_ack;
    logic          busy;
    logic          deadlock;
    logic          limit_hit;
    logic [CW-1:0] fire_count;
    logic          auto_ack = 1'b1;
    logic          man_ack = 1'b0;

    // Second instance with a firing limit of 4 and its own control inputs.
    logic          l_start = 1'b0;
    logic          l_halt = 1'b0;
    logic          l_step_mode = 1'b0;
    logic          l_step_req = 1'b0;
    logic          l_valid;
    logic [NT-1:0] l_onehot;
    logic [IW-1:0] l_idx;
    logic          l_ack;
    logic          l_busy;
    logic          l_deadlock;
    logic          l_limit;
    logic [CW-1:0] l_count;

    int n_pass = 0;
    int n_total = 0;
    int grants[$];

    assign fire_ack = auto_ack ? fire_valid : man_ack;
    assign l_ack    = l_valid;

    always #5 clk = ~clk;

    pn_fire_scheduler #(.NT(NT), .IW(IW), .CW(CW), .MAX_FIRES(0)) u_dut (
        .clk (clk), .rst (rst), .start (start), .halt (halt),
        .step_mode (step_mode), .step_req (step_req),
        .enabled (enabled), .prio_mask (prio_mask),
        .fire_valid (fire_valid), .fire_onehot (fire_onehot), .fire_idx (fire_idx),
        .fire_ack (fire_ack), .busy (busy), .deadlock (deadlock),
        .limit_hit (limit_hit), .fire_count (fire_count)
    );

    pn_fire_scheduler #(.NT(NT), .IW(IW), .CW(CW), .MAX_FIRES(4)) u_lim (
        .clk (clk), .rst (rst), .start (l_start), .halt (l_halt),
        .step_mode (l_step_mode), .step_req (l_step_req),
        .enabled (enabled), .prio_mask (prio_mask),
        .fire_valid (l_valid), .fire_onehot (l_onehot), .fire_idx (l_idx),
        .fire_ack (l_ack), .busy (l_busy), .deadlock (l_deadlock),
        .limit_hit (l_limit), .fire_count (l_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Selection rule: immediate class if any enabled, else all enabled;
    // first candidate strictly after the last granted index, wrapping.
    function automatic int model_pick(logic [NT-1:0] en, logic [NT-1:0] pm, int last);
        logic [NT-1:0] c;
        c = ((en & pm) != '0) ? (en & pm) : en;
        for (int k = 1; k <= NT; k++) begin
            int j;
            j = (last + k) % NT;
            if (c[j]) return j;
        end
        return -1;
    endfunction

    // Model state: completed firings, last granted index, inputs seen in the previous cycle.
    int            m_count = 0;
    int            m_last = NT - 1;
    int            exp_idx = 0;
    logic          prev_fv = 1'b0;
    logic [NT-1:0] prev_en = '0;
    logic [NT-1:0] prev_pm = '0;

    // Compare process for the unlimited instance, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            m_count = 0;
            m_last  = NT - 1;
            prev_fv = 1'b0;
        end else begin
            check("fire_count", 32'(fire_count), 32'(m_count));
            if (!fire_valid) begin
                check("idle_onehot_zero", 32'(fire_onehot), 32'd0);
                check("idle_idx_zero", 32'(fire_idx), 32'd0);
            end else begin
                // The grant was chosen from the inputs of the evaluation cycle just before the request rose.
                if (!prev_fv) exp_idx = model_pick(prev_en, prev_pm, m_last);
                check("grant_idx", 32'(fire_idx), 32'(exp_idx));
                check("grant_onehot", 32'(fire_onehot), 32'(1) << exp_idx);
                check("busy_in_fire", 32'(busy), 32'd1);
            end
            if (fire_valid && fire_ack) begin
                m_count++;
                m_last = exp_idx;
                grants.push_back(int'(fire_idx));
            end
            if (start && !busy) begin
                m_count = 0;
                m_last  = NT - 1;
            end
            prev_fv = fire_valid;
            prev_en = enabled;
            prev_pm = prio_mask;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Advance until the unlimited instance raises a request; returns in that FIRE cycle.
    task automatic wait_fire();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!fire_valid && n < 40);
        check("fire_request_seen", 32'(fire_valid), 32'd1);
    endtask

    task automatic wait_lim_fire();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!l_valid && n < 40);
        check("lim_request_seen", 32'(l_valid), 32'd1);
    endtask

    initial begin
        int exp_rr[6];
        int exp_pr[4];
        int exp_lim[4];
        exp_rr  = '{2, 5, 9, 2, 5, 9};
        exp_pr  = '{6, 6, 6, 8};
        exp_lim = '{0, 4, 0, 4};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_fire_valid", 32'(fire_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_deadlock", 32'(deadlock), 32'd0);
        check("rst_limit_hit", 32'(limit_hit), 32'd0);
        check("rst_count", 32'(fire_count), 32'd0);
        check("rst_lim_valid", 32'(l_valid), 32'd0);
        rst = 1'b0;
        tick();

        // 1. Basic run on bit 0, halted during the third request.
        enabled = 15'h0001;
        grants.delete();
        pulse_start();
        check("t1_busy_after_start", 32'(busy), 32'd1);
        wait_fire();
        wait_fire();
        wait_fire();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("t1_count", 32'(fire_count), 32'd3);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_ngrants", 32'(grants.size()), 32'd3);
        foreach (grants[i]) check("t1_grant", 32'(grants[i]), 32'd0);

        // 2. Round robin over bits 2, 5, 9.
        enabled = 15'h0224;
        grants.delete();
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            wait_fire();
            if (i == 5) halt = 1'b1;
        end
        tick();
        halt = 1'b0;
        check("t2_ngrants", 32'(grants.size()), 32'd6);
        check("t2_count", 32'(fire_count), 32'd6);
        for (int i = 0; i < 6 && i < grants.size(); i++) begin
            check("t2_grant", 32'(grants[i]), 32'(exp_rr[i]));
            if (i > 0) check("t2_no_repeat", 32'(grants[i] == grants[i-1]), 32'd0);
        end

        // 3. Immediate class inhibits the timed one until it is dropped.
        enabled   = 15'h0140;
        prio_mask = 15'h0040;
        grants.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            wait_fire();
            if (i == 2) enabled = 15'h0100;
            if (i == 3) halt = 1'b1;
        end
        tick();
        halt = 1'b0;
        prio_mask = '0;
        check("t3_ngrants", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check("t3_grant", 32'(grants[i]), 32'(exp_pr[i]));

        // 4. Deadlock after two firings, then a restart clears it.
        enabled = 15'h0008;
        pulse_start();
        wait_fire();
        wait_fire();
        enabled = '0;
        repeat (3) tick();
        check("t4_deadlock", 32'(deadlock), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_count", 32'(fire_count), 32'd2);
        pulse_start();
        check("t4_deadlock_cleared", 32'(deadlock), 32'd0);
        check("t4_count_cleared", 32'(fire_count), 32'd0);
        check("t4_busy_eval", 32'(busy), 32'd1);
        repeat (2) tick();

        // 6a. Halt during FIRE with the ack held back for five cycles.
        auto_ack = 1'b0;
        enabled  = 15'h0002;
        pulse_start();
        wait_fire();
        halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_valid_held", 32'(fire_valid), 32'd1);
            check("t6_onehot_held", 32'(fire_onehot), 32'h0002);
        end
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        halt    = 1'b0;
        check("t6_valid_dropped", 32'(fire_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_count", 32'(fire_count), 32'd1);

        // 6b. Asynchronous reset in the middle of a handshake.
        auto_ack = 1'b1;
        pulse_start();
        wait_fire();
        wait_fire();
        auto_ack = 1'b0;
        check("t6b_count_before", 32'(fire_count), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6b_valid", 32'(fire_valid), 32'd0);
        check("t6b_onehot", 32'(fire_onehot), 32'd0);
        check("t6b_count", 32'(fire_count), 32'd0);
        check("t6b_busy", 32'(busy), 32'd0);
        tick();
        rst      = 1'b0;
        auto_ack = 1'b1;
        tick();
        check("t6b_idle_after", 32'(busy), 32'd0);

        // 5. Step mode with a firing limit of 4 on the second instance.
        enabled     = 15'h0011;
        l_step_mode = 1'b1;
        l_start     = 1'b1;
        tick();
        l_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_lim_fire();
            check("t5_grant", 32'(l_idx), 32'(exp_lim[k]));
            check("t5_onehot", 32'(l_onehot), 32'(1) << exp_lim[k]);
            tick();
            check("t5_count", 32'(l_count), 32'(k + 1));
            if (k < 3) begin
                repeat (2) tick();
                check("t5_paused", 32'(l_valid), 32'd0);
                check("t5_busy_paused", 32'(l_busy), 32'd1);
                l_step_req = 1'b1;
                tick();
                l_step_req = 1'b0;
            end
        end
        check("t5_limit_hit", 32'(l_limit), 32'd1);
        check("t5_done_busy", 32'(l_busy), 32'd0);
        l_step_req = 1'b1;
        tick();
        l_step_req = 1'b0;
        repeat (3) begin
            tick();
            check("t5_step_ignored", 32'(l_valid), 32'd0);
        end
        check("t5_count_final", 32'(l_count), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pn_fire_scheduler.md
Name: pn_fire_scheduler

Overview:
- Sequencing controller for the Petri-net marking datapath.
- Each cycle the datapath presents which transitions are enabled. This block picks exactly one to fire using a two-class, round-robin selection, then handshakes the firing with the datapath.
- Counts firings, detects deadlock (nothing enabled), and supports run/step/halt control plus an optional firing limit.
- Replaces the fixed-priority firing chain, so that a low-index transition cannot starve high-index ones.

Parameters:
- NT, 15, number of transitions (width of enable/grant vectors).
- IW, 4, width of fire_idx; must satisfy 2^IW >= NT.
- CW, 30, width of fire_count.
- MAX_FIRES, 0, firing limit; 0 means unlimited.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  pulse: begin a run (accepted in IDLE, DEAD, DONE)
- halt  in  1  level: stop after the current handshake completes
- step_mode  in  1  level: 1 means pause after each firing
- step_req  in  1  pulse: release one firing while in PAUSE
- enabled  in  NT  per-transition enable from the datapath; combinational from the current marking
- prio_mask  in  NT  1 marks an immediate (high-class) transition
- fire_valid  out  1  firing request to the datapath
- fire_onehot  out  NT  one-hot selected transition
- fire_idx  out  IW  index of the selected transition
- fire_ack  in  1  datapath has applied the marking update
- busy  out  1  state is not IDLE, DEAD or DONE
- deadlock  out  1  sticky: no transition was enabled
- limit_hit  out  1  sticky: MAX_FIRES reached
- fire_count  out  CW  completed firings, saturating

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer rr_ptr = NT-1, so the first search starts at index 0.
- States: IDLE, EVAL, FIRE, PAUSE, DEAD, DONE.
- IDLE/DEAD/DONE, start=1:
  - next state EVAL;
  - fire_count, deadlock and limit_hit cleared;
  - rr_ptr reset to NT-1.
- EVAL (one cycle):
  - Candidate set: cand = enabled & prio_mask if that is nonzero, otherwise cand = enabled. Immediate transitions therefore inhibit timed ones.
  - Pick the first set bit of cand, searching from rr_ptr+1 upward and wrapping modulo NT.
  - cand == 0: go to DEAD and set deadlock.
  - halt=1: go to IDLE, no grant issued.
  - Otherwise: register fire_onehot and fire_idx, go to FIRE.
- FIRE:
  - fire_valid=1; fire_onehot and fire_idx held stable.
  - halt does not drop the request; a request is never withdrawn.
  - Wait for fire_ack. On the ack cycle:
    - rr_ptr <= fire_idx;
    - fire_count += 1, saturating at all-ones;
    - fire_valid deasserts on the next edge.
  - Next state after ack, in priority order:
    1. If MAX_FIRES != 0 and the new count equals MAX_FIRES: DONE, set limit_hit.
    2. Else if halt: IDLE.
    3. Else if step_mode: PAUSE.
    4. Else: EVAL.
- Throughput: one firing per 2 cycles when ack arrives in the first FIRE cycle.
- Timing contract: the datapath updates the marking on the ack edge, and enabled must reflect the new marking in the following EVAL cycle.
- PAUSE:
  - step_req=1: go to EVAL.
  - halt=1: go to IDLE.
  - halt wins if both are asserted.
  - Clearing step_mode while in PAUSE also goes to EVAL.
- fire_ack outside FIRE is ignored. start outside IDLE/DEAD/DONE is ignored.
- Asynchronous reset mid-handshake aborts immediately: fire_valid=0, count cleared. The datapath must reset its marking in the same way.
- fire_onehot and fire_idx read 0 whenever fire_valid=0.

Decomposition:
- Shared package pn_pkg:
  - state enum (IDLE, EVAL, FIRE, PAUSE, DEAD, DONE);
  - NT/IW defaults for the current net.
- One sub-module, pn_rr_pick: combinational rotate, find-first-set, rotate-back picker.
  - Inputs: cand[NT], ptr[IW].
  - Outputs: gnt_onehot[NT], gnt_idx[IW], any.

Test Plan:
1. Basic run. enabled=15'h0001 (bit 0) held, prio_mask=0, ack the same cycle as each request, halt after 3 firings → three grants idx=0; fire_count=3; IDLE; busy=0.
2. Round robin. enabled=bits{2,5,9} constant, free run with immediate acks → grant sequence 2,5,9,2,5,9; no index is granted twice consecutively.
3. Priority class. enabled=bits{6,8}, prio_mask=bit6 → only idx 6 is granted while bit6 stays enabled. Drop bit6 → next grant is idx 8.
4. Deadlock. After 2 firings drive enabled=0 → EVAL then DEAD; deadlock=1; fire_count=2. start → deadlock clears, count=0.
5. Step and limit. step_mode=1, MAX_FIRES=4 → one grant per step_req pulse; 4th ack → DONE, limit_hit=1; further step_req is ignored.
6. Halt/reset edge cases:
   - halt during FIRE with ack delayed 5 cycles → fire_valid stays high until ack, then IDLE, count incremented once;
   - rst asserted in FIRE → outputs 0 asynchronously.
